alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//   Host-side initiator for the 8-bit ALU tile. Accepts a command {op, flag select, A, B}
//   on a valid/ready interface and drives the ALU's shared data bus and control byte
//   to load B, then A. Waits for the result to settle, then captures the 14-bit result,
//   flag and overflow into a response held on a valid/ready interface.
//   Sits between a command source (test controller or CPU) and the ALU's ui_in/uio_in/uo_out/uio_out pins.
// PARAMETERS
//   SETTLE_CYCLES  1  cycles spent in WAIT after A is loaded, before capture; legal range >=1
// PORTS
//   clk          in   1   single clock
//   rst_n        in   1   asynchronous, active-low reset
//   cmd_valid    in   1   command offered
//   cmd_ready    out  1   command accepted when cmd_valid&cmd_ready
//   cmd_op       in   3   ALU opcode
//   cmd_flagsel  in   2   flag select
//   cmd_a        in   8   operand A
//   cmd_b        in   8   operand B
//   rsp_valid    out  1   response available
//   rsp_ready    in   1   response consumed when rsp_valid&rsp_ready
//   rsp_result   out  14  {alu_res_hi[5:0], alu_res_lo}
//   rsp_flag     out  1   alu_res_hi[6]
//   rsp_ovf      out  1   alu_res_hi[7]
//   alu_data     out  8   to ALU ui_in
//   alu_ctrl     out  8   to ALU uio_in: [2:0]=op, [3]=enA, [5:4]=flagsel, [7:6]=0
//   alu_res_lo   in   8   from ALU uo_out
//   alu_res_hi   in   8   from ALU uio_out
//   busy         out  1   state != IDLE
// BEHAVIOUR
//   - The ALU loads B on every edge where enA=0 and loads A on every edge where enA=1.
//     Outside LOAD_B, the block therefore holds enA=1 with alu_data = the registered A.
//   - Reset values: cmd_ready=1, rsp_valid=0, rsp_result/flag/ovf=0, alu_data=8'h00,
//     alu_ctrl=8'h08, busy=0. All command and response registers clear.
//   - Command fields are registered at accept. Later changes on cmd_* have no effect.
//   - FSM, all outputs registered:
//     IDLE   : cmd_ready=1. On accept -> LOAD_B.
//     LOAD_B : alu_data=B, alu_ctrl={2'b0,flagsel,1'b0,op} -> LOAD_A.
//     LOAD_A : alu_data=A, alu_ctrl={2'b0,flagsel,1'b1,op} -> WAIT, counter=0.
//     WAIT   : hold bus. On counter==SETTLE_CYCLES-1, capture alu_res_hi/lo into the
//              rsp registers -> RESP; otherwise counter+1.
//     RESP   : rsp_valid=1, rsp_* stable. On rsp_ready -> IDLE.
//   - Latency: with acceptance in cycle 0, rsp_valid rises in cycle 3+SETTLE_CYCLES.
//     One IDLE bubble separates commands; throughput is 1 command per 4+SETTLE_CYCLES cycles, minimum.
//   - Backpressure: RESP may hold indefinitely. cmd_ready stays 0 and the bus is unchanged.
//   - cmd_valid outside IDLE is ignored (not queued).
//   - rsp_ready while rsp_valid=0 has no effect.
//   - Reset mid-operation: immediate return to reset values. The in-flight command is
//     dropped and no response is produced.
//   - No arithmetic in this block. The result is a raw 14-bit capture: no sign extension
//     and no saturation.
// STRUCTURE
//   - Shared package alu_seq_pkg holds:
//     - op codes: ADD=0, SUB=1, SHR=2, SHL=3, AND=4, OR=5, XOR=6, MUL=7
//     - flag selects: GT=0, EQ=1, ZERO=2, EVEN=3
//     - ctrl bit positions: OP_LSB=0, ENA_BIT=3, FSEL_LSB=4
//     - state enum: IDLE, LOAD_B, LOAD_A, WAIT, RESP
//   - Single flat module; no sub-module is warranted.
//   - Counter width: $clog2(SETTLE_CYCLES+1).
// TESTING (bench instantiates the ALU tile behind this block)
//   1. ADD A=200 B=100 GT -> rsp_result=14'h012C, flag=1, ovf=1; rsp_valid in cycle 4 (SETTLE_CYCLES=1).
//   2. SUB A=5 B=7 EQ -> rsp_result=14'h3FFE, flag=0, ovf=1.
//   3. MUL A=255 B=255 ZERO -> rsp_result=14'h3E01, flag=0, ovf=1. AND A=8'hF0 B=8'h0F -> 0, ovf=0.
//   4. Hold rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0, alu_data/ctrl frozen.
//      Release -> IDLE next cycle.
//   5. Assert rst_n=0 during LOAD_A -> alu_ctrl=8'h08, rsp_valid=0 asynchronously.
//      Next command (XOR 8'hAA^8'h55) -> 14'h00FF.
//   6. SETTLE_CYCLES=3, back-to-back cmd_valid -> rsp_valid cycle 6; next accept one cycle after rsp handshake.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcodes, flag selects, control-byte layout and FSM states
//               shared by the ALU command sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_SHR = 3'd2;
   localparam logic [2:0] OP_SHL = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   localparam logic [1:0] FSEL_GT   = 2'd0;
   localparam logic [1:0] FSEL_EQ   = 2'd1;
   localparam logic [1:0] FSEL_ZERO = 2'd2;
   localparam logic [1:0] FSEL_EVEN = 2'd3;

   localparam int OP_LSB   = 0;
   localparam int ENA_BIT  = 3;
   localparam int FSEL_LSB = 4;

   // Idle bus state: A-load enabled so the tile keeps re-latching a known value.
   localparam logic [7:0] CTRL_RESET = 8'h08;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_B = 3'd1,
      ST_LOAD_A = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

   function automatic logic [7:0] pack_ctrl(input logic [2:0] op,
                                            input logic [1:0] fsel,
                                            input logic       ena);
      logic [7:0] c;
      c                  = 8'h00;
      c[OP_LSB +: 3]     = op;
      c[ENA_BIT]         = ena;
      c[FSEL_LSB +: 2]   = fsel;
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// alu_cmd_sequencer : drives B then A onto the ALU tile bus, waits for the
//                     result to settle and returns it on a valid/ready port.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [1:0]  cmd_flagsel,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [13:0] rsp_result,
   output logic        rsp_flag,
   output logic        rsp_ovf,
   output logic [7:0]  alu_data,
   output logic [7:0]  alu_ctrl,
   input  logic [7:0]  alu_res_lo,
   input  logic [7:0]  alu_res_hi,
   output logic        busy
);

   localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [1:0]        fsel_q, fsel_d;
   logic [7:0]        a_q, a_d;
   logic [7:0]        data_q, data_d;
   logic [7:0]        ctrl_q, ctrl_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [13:0]       rsp_result_q, rsp_result_d;
   logic              rsp_flag_q, rsp_flag_d;
   logic              rsp_ovf_q, rsp_ovf_d;
   logic              busy_q, busy_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      fsel_d       = fsel_q;
      a_d          = a_q;
      data_d       = data_q;
      ctrl_d       = ctrl_q;
      cmd_ready_d  = cmd_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_flag_d   = rsp_flag_q;
      rsp_ovf_d    = rsp_ovf_q;

      // Outputs are registered, so each branch sets up the bus for the next state.
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d        = cmd_op;
               fsel_d      = cmd_flagsel;
               a_d         = cmd_a;
               data_d      = cmd_b;
               ctrl_d      = pack_ctrl(cmd_op, cmd_flagsel, 1'b0);
               cmd_ready_d = 1'b0;
               state_d     = ST_LOAD_B;
            end
         end
         ST_LOAD_B: begin
            data_d  = a_q;
            ctrl_d  = pack_ctrl(op_q, fsel_q, 1'b1);
            state_d = ST_LOAD_A;
         end
         ST_LOAD_A: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               rsp_result_d = {alu_res_hi[5:0], alu_res_lo};
               rsp_flag_d   = alu_res_hi[6];
               rsp_ovf_d    = alu_res_hi[7];
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         op_q         <= 3'd0;
         fsel_q       <= 2'd0;
         a_q          <= 8'h00;
         data_q       <= 8'h00;
         ctrl_q       <= CTRL_RESET;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 14'd0;
         rsp_flag_q   <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         fsel_q       <= fsel_d;
         a_q          <= a_d;
         data_q       <= data_d;
         ctrl_q       <= ctrl_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_flag_q   <= rsp_flag_d;
         rsp_ovf_q    <= rsp_ovf_d;
         busy_q       <= busy_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flag   = rsp_flag_q;
   assign rsp_ovf    = rsp_ovf_q;
   assign alu_data   = data_q;
   assign alu_ctrl   = ctrl_q;
   assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// tb_alu_cmd_sequencer : two sequencers (settle 1 and 3), each driving a
//                        behavioural ALU tile; directed vectors and corner cases.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;
   import alu_seq_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // ALU tile behaviour: {ovf, flag, result[13:0]}
   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [1:0] fs,
                                         input logic [7:0] a, input logic [7:0] b);
      logic [15:0] r;
      logic        f, o;
      case (op)
         3'd0:    r = {8'h00, a} + {8'h00, b};
         3'd1:    r = {8'h00, a} - {8'h00, b};
         3'd2:    r = {8'h00, a} >> b[2:0];
         3'd3:    r = {8'h00, a} << b[2:0];
         3'd4:    r = {8'h00, a & b};
         3'd5:    r = {8'h00, a | b};
         3'd6:    r = {8'h00, a ^ b};
         default: r = {8'h00, a} * {8'h00, b};
      endcase
      o = (op == 3'd1) ? (a < b) : (r > 16'd255);
      case (fs)
         2'd0:    f = (a > b);
         2'd1:    f = (a == b);
         2'd2:    f = (r == 16'd0);
         default: f = ~r[0];
      endcase
      return {o, f, r[13:0]};
   endfunction

   // ---------------- instance with SETTLE_CYCLES = 1 ----------------
   logic        rst1_n, cv1, cr1, rv1, rr1, fl1, ov1, busy1;
   logic [2:0]  op1;
   logic [1:0]  fs1;
   logic [7:0]  a1, b1, data1, ctrl1, rlo1, rhi1, ra1, rb1;
   logic [13:0] res1;

   alu_cmd_sequencer #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .cmd_valid(cv1), .cmd_ready(cr1),
      .cmd_op(op1), .cmd_flagsel(fs1), .cmd_a(a1), .cmd_b(b1),
      .rsp_valid(rv1), .rsp_ready(rr1), .rsp_result(res1), .rsp_flag(fl1), .rsp_ovf(ov1),
      .alu_data(data1), .alu_ctrl(ctrl1), .alu_res_lo(rlo1), .alu_res_hi(rhi1), .busy(busy1)
   );

   always @(posedge clk) begin
      if (ctrl1[3]) ra1 <= data1;
      else          rb1 <= data1;
   end
   assign {rhi1, rlo1} = alu_f(ctrl1[2:0], ctrl1[5:4], ra1, rb1);

   // ---------------- instance with SETTLE_CYCLES = 3 ----------------
   logic        rst3_n, cv3, cr3, rv3, rr3, fl3, ov3, busy3;
   logic [2:0]  op3;
   logic [1:0]  fs3;
   logic [7:0]  a3, b3, data3, ctrl3, rlo3, rhi3, ra3, rb3;
   logic [13:0] res3;

   alu_cmd_sequencer #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .cmd_valid(cv3), .cmd_ready(cr3),
      .cmd_op(op3), .cmd_flagsel(fs3), .cmd_a(a3), .cmd_b(b3),
      .rsp_valid(rv3), .rsp_ready(rr3), .rsp_result(res3), .rsp_flag(fl3), .rsp_ovf(ov3),
      .alu_data(data3), .alu_ctrl(ctrl3), .alu_res_lo(rlo3), .alu_res_hi(rhi3), .busy(busy3)
   );

   always @(posedge clk) begin
      if (ctrl3[3]) ra3 <= data3;
      else          rb3 <= data3;
   end
   assign {rhi3, rlo3} = alu_f(ctrl3[2:0], ctrl3[5:4], ra3, rb3);

   // ---------------- checking helpers ----------------
   typedef struct {
      logic [2:0]  op;
      logic [1:0]  fs;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [13:0] res;
      logic        flag;
      logic        ovf;
      string       name;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_ctrl(input logic [2:0] op, input logic [1:0] fs,
                                           input logic ena);
      return {2'b00, fs, ena, op};
   endfunction

   // Accept a command on dut1 and follow it to the response; returns on rsp_valid.
   task automatic issue1(input vec_t v);
      int k;
      @(negedge clk);
      chk({v.name, " cmd_ready"}, 32'(cr1), 32'd1);
      op1 = v.op; fs1 = v.fs; a1 = v.a; b1 = v.b; cv1 = 1'b1;
      @(negedge clk);
      cv1 = 1'b0; op1 = ~v.op; fs1 = ~v.fs; a1 = ~v.a; b1 = ~v.b;
      chk({v.name, " loadB bus"}, {8'h00, busy1, cr1, 6'd0, ctrl1, data1},
          {8'h00, 1'b1, 1'b0, 6'd0, exp_ctrl(v.op, v.fs, 1'b0), v.b});
      @(negedge clk);
      chk({v.name, " loadA bus"}, {16'h0000, ctrl1, data1},
          {16'h0000, exp_ctrl(v.op, v.fs, 1'b1), v.a});
      k = 2;
      while (!rv1 && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk({v.name, " latency"}, 32'(k), 32'd4);
      chk({v.name, " result"}, {16'h0000, ov1, fl1, res1}, {16'h0000, v.ovf, v.flag, v.res});
   endtask

   task automatic release1(input string nm);
      rr1 = 1'b1;
      @(negedge clk);
      rr1 = 1'b0;
      chk({nm, " after handshake"}, {29'd0, rv1, cr1, busy1}, {29'd0, 1'b0, 1'b1, 1'b0});
   endtask

   initial begin
      int k;
      vec_t bp, rv, xv;

      tbl[0] = '{OP_ADD, FSEL_GT,   8'd200, 8'd100, 14'h012C, 1'b1, 1'b1, "add"};
      tbl[1] = '{OP_SUB, FSEL_EQ,   8'd5,   8'd7,   14'h3FFE, 1'b0, 1'b1, "sub_neg"};
      tbl[2] = '{OP_MUL, FSEL_ZERO, 8'd255, 8'd255, 14'h3E01, 1'b0, 1'b1, "mul_max"};
      tbl[3] = '{OP_AND, FSEL_ZERO, 8'hF0,  8'h0F,  14'h0000, 1'b1, 1'b0, "and_zero"};
      tbl[4] = '{OP_OR,  FSEL_EQ,   8'h12,  8'h34,  14'h0036, 1'b0, 1'b0, "or"};
      tbl[5] = '{OP_SHL, FSEL_EVEN, 8'h81,  8'd1,   14'h0102, 1'b1, 1'b1, "shl"};
      tbl[6] = '{OP_SHR, FSEL_GT,   8'h80,  8'd3,   14'h0010, 1'b1, 1'b0, "shr"};
      tbl[7] = '{OP_XOR, FSEL_EVEN, 8'hAA,  8'h55,  14'h00FF, 1'b0, 1'b0, "xor"};
      tbl[8] = '{OP_ADD, FSEL_EQ,   8'd7,   8'd7,   14'h000E, 1'b1, 1'b0, "add_eq"};
      tbl[9] = '{OP_SUB, FSEL_GT,   8'd9,   8'd3,   14'h0006, 1'b1, 1'b0, "sub_pos"};

      rst1_n = 1'b0; rst3_n = 1'b0;
      cv1 = 1'b0; rr1 = 1'b0; op1 = 3'd0; fs1 = 2'd0; a1 = 8'h00; b1 = 8'h00;
      cv3 = 1'b0; rr3 = 1'b0; op3 = 3'd0; fs3 = 2'd0; a3 = 8'h00; b3 = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset outputs", {cr1, rv1, fl1, ov1, busy1, res1, ctrl1},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 8'h08});
      chk("reset data", 32'(data1), 32'h00);
      rst1_n = 1'b1; rst3_n = 1'b1;

      // rsp_ready with nothing pending
      @(negedge clk);
      rr1 = 1'b1;
      @(negedge clk);
      rr1 = 1'b0;
      chk("idle rsp_ready", {30'd0, rv1, cr1}, {30'd0, 1'b0, 1'b1});

      for (int i = 0; i < 10; i++) begin
         issue1(tbl[i]);
         release1(tbl[i].name);
      end

      // Backpressure: response held 10 cycles while cmd_valid is offered
      bp = tbl[1];
      issue1(bp);
      cv1 = 1'b1; op1 = OP_MUL; a1 = 8'h11; b1 = 8'h22;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("backpressure hold", {rv1, cr1, res1, data1, ctrl1},
             {1'b1, 1'b0, bp.res, bp.a, exp_ctrl(bp.op, bp.fs, 1'b1)});
      end
      cv1 = 1'b0;
      release1("backpressure");

      // Reset asserted while A is on the bus
      rv = '{OP_ADD, FSEL_GT, 8'd1, 8'd2, 14'h0003, 1'b0, 1'b0, "rst"};
      @(negedge clk);
      op1 = rv.op; fs1 = rv.fs; a1 = rv.a; b1 = rv.b; cv1 = 1'b1;
      @(negedge clk);
      cv1 = 1'b0;
      @(negedge clk);
      chk("pre-reset loadA", 32'(ctrl1), 32'(exp_ctrl(rv.op, rv.fs, 1'b1)));
      #1 rst1_n = 1'b0;
      #1;
      chk("async reset", {rv1, cr1, busy1, 5'd0, ctrl1, data1, 8'h00},
          {1'b0, 1'b1, 1'b0, 5'd0, 8'h08, 8'h00, 8'h00});
      @(negedge clk);
      rst1_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("no response after reset", {30'd0, rv1, busy1}, 32'd0);
      xv = tbl[7];
      xv.name = "xor_after_rst";
      issue1(xv);
      release1(xv.name);

      // SETTLE_CYCLES=3 with cmd_valid held high for two commands
      @(negedge clk);
      chk("s3 ready", 32'(cr3), 32'd1);
      op3 = OP_ADD; fs3 = FSEL_GT; a3 = 8'd200; b3 = 8'd100; cv3 = 1'b1;
      @(negedge clk);
      op3 = OP_MUL; fs3 = FSEL_EVEN; a3 = 8'd3; b3 = 8'd4;
      chk("s3 busy", 32'(busy3), 32'd1);
      k = 1;
      while (!rv3 && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk("s3 latency", 32'(k), 32'd6);
      chk("s3 result1", {16'h0000, ov3, fl3, res3}, {16'h0000, 1'b1, 1'b1, 14'h012C});
      rr3 = 1'b1;
      @(negedge clk);
      rr3 = 1'b0;
      chk("s3 idle bubble", {30'd0, rv3, cr3}, {30'd0, 1'b0, 1'b1});
      @(negedge clk);
      chk("s3 second accept", {16'h0000, busy3, 7'd0, data3}, {16'h0000, 1'b1, 7'd0, 8'd4});
      cv3 = 1'b0;
      k = 8;
      while (!rv3 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("s3 latency2", 32'(k), 32'd13);
      chk("s3 result2", {16'h0000, ov3, fl3, res3}, {16'h0000, 1'b0, 1'b1, 14'h000C});
      rr3 = 1'b1;
      @(negedge clk);
      rr3 = 1'b0;
      chk("s3 done", {30'd0, rv3, cr3}, {30'd0, 1'b0, 1'b1});

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
